apb_mtimer: RTL and testbench



---
 rtl/apb_mtimer_pkg.sv | 38 +++
 rtl/apb_mtimer_prescaler.sv | 38 +++
 rtl/apb_mtimer.sv | 153 +++++++++++++++
 tb/tb_apb_mtimer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mtimer_pkg.sv
// -----------------------------------------------------------------------------
// mtimer_pkg
// Shared definitions for the APB machine timer: register offsets (byte offsets
// within the 32-byte window), CTRL bit positions, the mtimecmp reset value and
// a byte-strobe merge helper used by every writable register.
// -----------------------------------------------------------------------------
package mtimer_pkg;

    localparam logic [4:0] MT_MTIME_LO    = 5'h00;
    localparam logic [4:0] MT_MTIME_HI    = 5'h04;
    localparam logic [4:0] MT_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MT_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] MT_CTRL        = 5'h10;
    localparam logic [4:0] MT_PRESCALE    = 5'h14;
    localparam logic [4:0] MT_STATUS      = 5'h18;
    localparam logic [4:0] MT_RESERVED    = 5'h1C;

    localparam int MT_CTRL_EN = 0;
    localparam int MT_CTRL_IE = 1;

    // All-ones so that a freshly reset timer never reports a pending compare.
    localparam logic [63:0] MT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the bytes of cur whose strobe bit is set.
    function automatic logic [31:0] mt_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  stb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (stb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_mtimer_prescaler.sv
// -----------------------------------------------------------------------------
// mtimer_prescaler
// Divides APB_PCLK by (prescale + 1) while enabled and emits a one-cycle tick
// each time the divider wraps.
// Ports:
//   APB_PCLK     in   clock
//   APB_PRESETn  in   asynchronous active-low reset
//   en           in   count enable; when low, pcnt is frozen and no tick
//   prescale     in   terminal count (0 -> tick every cycle)
//   clr          in   synchronous clear of pcnt (software reprogramming)
//   tick         out  one-cycle pulse, high in the cycle where pcnt == prescale
// -----------------------------------------------------------------------------
module mtimer_prescaler (
    input  logic        APB_PCLK,
    input  logic        APB_PRESETn,
    input  logic        en,
    input  logic [31:0] prescale,
    input  logic        clr,
    output logic        tick
);

    logic [31:0] pcnt;
    logic        match;

    assign match = (pcnt == prescale);
    assign tick  = en & match;

    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= match ? 32'd0 : pcnt + 32'd1;
        end
    end

endmodule

// File: rtl/apb_mtimer.sv
// -----------------------------------------------------------------------------
// apb_mtimer
// Zero-wait-state APB machine timer: 64-bit prescaled mtime counter, 64-bit
// mtimecmp compare register and a registered level interrupt.
// Ports:
//   APB_PCLK, APB_PRESETn     clock, asynchronous active-low reset
//   APB_paddr                 byte address (bits [4:0] decoded)
//   APB_pdata / APB_prdata    write / read data
//   APB_psel, APB_penable     APB select / access phase
//   APB_pwrite, APB_pstb      direction, byte write strobes
//   APB_pready, APB_perr      transfer complete, slave error
//   interrupt                 timer interrupt level (IE & mtime >= mtimecmp)
// Build option:
//   APB_MTIMER_HI_LATCH_EN    when defined, reading MTIME_LO snapshots
//                             mtime[63:32] so the following MTIME_HI read is
//                             coherent with it.
// -----------------------------------------------------------------------------
module apb_mtimer
    import mtimer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  APB_PCLK,
    input  logic                  APB_PRESETn,
    input  logic [ADDR_WIDTH-1:0] APB_paddr,
    input  logic [DATA_WIDTH-1:0] APB_pdata,
    output logic [DATA_WIDTH-1:0] APB_prdata,
    input  logic                  APB_psel,
    input  logic                  APB_penable,
    input  logic                  APB_pwrite,
    input  logic [3:0]            APB_pstb,
    output logic                  APB_pready,
    output logic                  APB_perr,
    output logic                  interrupt
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [1:0]  ctrl;
    logic [31:0] prescale;
    logic        irq_q;

    logic [4:0]  off;
    logic        access;
    logic        err;
    logic        wr;
    logic        rd;
    logic        pend;
    logic        tick;
    logic        pcnt_clr;

    // Upper address bits are outside the decoded window.
    logic        unused_paddr;
    assign unused_paddr = ^APB_paddr[ADDR_WIDTH-1:5];

    assign off = APB_paddr[4:0];

    // Gating with reset makes the combinational outputs drop immediately
    // when reset is asserted in the middle of an access phase.
    assign access = APB_psel & APB_penable & APB_PRESETn;

    assign err = access & ((off[1:0] != 2'b00) ||
                           (off == MT_RESERVED) ||
                           (APB_pwrite && (off == MT_STATUS)));

    assign wr   = access &  APB_pwrite & ~err;
    assign rd   = access & ~APB_pwrite & ~err;
    assign pend = (mtime >= mtimecmp);

    // Reprogramming the rate or touching the enable restarts the divider.
    assign pcnt_clr = wr & ((off == MT_PRESCALE) || ((off == MT_CTRL) && APB_pstb[0]));

    mtimer_prescaler u_prescaler (
        .APB_PCLK    (APB_PCLK),
        .APB_PRESETn (APB_PRESETn),
        .en          (ctrl[MT_CTRL_EN]),
        .prescale    (prescale),
        .clr         (pcnt_clr),
        .tick        (tick)
    );

    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            mtime    <= '0;
            mtimecmp <= MT_MTIMECMP_RST;
            ctrl     <= '0;
            prescale <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= ctrl[MT_CTRL_IE] & pend;

            // A software write to either mtime half wins over a same-cycle tick.
            if (wr && (off == MT_MTIME_LO)) begin
                mtime <= {mtime[63:32], mt_merge(mtime[31:0], APB_pdata, APB_pstb)};
            end else if (wr && (off == MT_MTIME_HI)) begin
                mtime <= {mt_merge(mtime[63:32], APB_pdata, APB_pstb), mtime[31:0]};
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr && (off == MT_MTIMECMP_LO)) begin
                mtimecmp[31:0] <= mt_merge(mtimecmp[31:0], APB_pdata, APB_pstb);
            end
            if (wr && (off == MT_MTIMECMP_HI)) begin
                mtimecmp[63:32] <= mt_merge(mtimecmp[63:32], APB_pdata, APB_pstb);
            end
            if (wr && (off == MT_CTRL) && APB_pstb[0]) begin
                ctrl <= APB_pdata[1:0];
            end
            if (wr && (off == MT_PRESCALE)) begin
                prescale <= mt_merge(prescale, APB_pdata, APB_pstb);
            end
        end
    end

`ifdef APB_MTIMER_HI_LATCH_EN
    logic [31:0] mtime_hi_shadow;

    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            mtime_hi_shadow <= '0;
        end else if (rd && (off == MT_MTIME_LO)) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end
`endif

    always_comb begin
        APB_prdata = '0;
        if (rd) begin
            case (off)
                MT_MTIME_LO:    APB_prdata = mtime[31:0];
`ifdef APB_MTIMER_HI_LATCH_EN
                MT_MTIME_HI:    APB_prdata = mtime_hi_shadow;
`else
                MT_MTIME_HI:    APB_prdata = mtime[63:32];
`endif
                MT_MTIMECMP_LO: APB_prdata = mtimecmp[31:0];
                MT_MTIMECMP_HI: APB_prdata = mtimecmp[63:32];
                MT_CTRL:        APB_prdata = {30'd0, ctrl};
                MT_PRESCALE:    APB_prdata = prescale;
                MT_STATUS:      APB_prdata = {31'd0, pend};
                default:        APB_prdata = '0;
            endcase
        end
    end

    assign APB_pready = access;
    assign APB_perr   = err;
    assign interrupt  = irq_q;

endmodule

// File: tb/tb_apb_mtimer.sv
// -----------------------------------------------------------------------------
// tb_apb_mtimer
// Self-checking bench for apb_mtimer: reset/register-map vector table,
// hand-written timing sequences (prescaler, interrupt latency, wrap, optional
// MTIME_HI latch, reset mid-transfer) and randomized transfers checked against
// a cycle-level behavioural model of the timer.
// -----------------------------------------------------------------------------
module tb_apb_mtimer;

    logic        APB_PCLK = 1'b0;
    logic        APB_PRESETn;
    logic [31:0] APB_paddr;
    logic [31:0] APB_pdata;
    logic [31:0] APB_prdata;
    logic        APB_psel;
    logic        APB_penable;
    logic        APB_pwrite;
    logic [3:0]  APB_pstb;
    logic        APB_pready;
    logic        APB_perr;
    logic        interrupt;

    int tests = 0;
    int fails = 0;

    always #5 APB_PCLK = ~APB_PCLK;

    apb_mtimer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .APB_PCLK    (APB_PCLK),
        .APB_PRESETn (APB_PRESETn),
        .APB_paddr   (APB_paddr),
        .APB_pdata   (APB_pdata),
        .APB_prdata  (APB_prdata),
        .APB_psel    (APB_psel),
        .APB_penable (APB_penable),
        .APB_pwrite  (APB_pwrite),
        .APB_pstb    (APB_pstb),
        .APB_pready  (APB_pready),
        .APB_perr    (APB_perr),
        .interrupt   (interrupt)
    );

    // ---------------- behavioural reference model ----------------
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_en;
    logic        m_ie;
    logic [31:0] m_pre;
    logic [31:0] m_pcnt;
    logic        m_irq;
`ifdef APB_MTIMER_HI_LATCH_EN
    logic [31:0] m_shadow;
`endif

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    function automatic logic model_err(input logic [31:0] a, input logic w);
        return (a[1:0] != 2'b00) || (a[4:0] == 5'h1C) || (w && (a[4:0] == 5'h18));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (model_err(a, 1'b0)) return 32'd0;
        case (a[4:0])
            5'h00: return m_mtime[31:0];
`ifdef APB_MTIMER_HI_LATCH_EN
            5'h04: return m_shadow;
`else
            5'h04: return m_mtime[63:32];
`endif
            5'h08: return m_cmp[31:0];
            5'h0C: return m_cmp[63:32];
            5'h10: return {30'd0, m_ie, m_en};
            5'h14: return m_pre;
            5'h18: return (m_mtime >= m_cmp) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge APB_PCLK or negedge APB_PRESETn) begin : model
        logic        acc;
        logic        werr;
        logic        do_wr;
        logic        tk;
        logic [4:0]  o;
        logic [63:0] nt;
        logic [31:0] np;
        if (!APB_PRESETn) begin
            m_mtime <= 64'd0;
            m_cmp   <= {64{1'b1}};
            m_en    <= 1'b0;
            m_ie    <= 1'b0;
            m_pre   <= 32'd0;
            m_pcnt  <= 32'd0;
            m_irq   <= 1'b0;
`ifdef APB_MTIMER_HI_LATCH_EN
            m_shadow <= 32'd0;
`endif
        end else begin
            acc   = APB_psel && APB_penable;
            o     = APB_paddr[4:0];
            werr  = model_err(APB_paddr, APB_pwrite);
            do_wr = acc && APB_pwrite && !werr;
            tk    = m_en && (m_pcnt == m_pre);
            m_irq <= m_ie && (m_mtime >= m_cmp);
            nt = tk ? m_mtime + 64'd1 : m_mtime;
            np = !m_en ? m_pcnt : (tk ? 32'd0 : m_pcnt + 32'd1);
            if (do_wr) begin
                case (o)
                    5'h00: nt = {m_mtime[63:32], bmerge(m_mtime[31:0], APB_pdata, APB_pstb)};
                    5'h04: nt = {bmerge(m_mtime[63:32], APB_pdata, APB_pstb), m_mtime[31:0]};
                    5'h08: m_cmp[31:0]  <= bmerge(m_cmp[31:0], APB_pdata, APB_pstb);
                    5'h0C: m_cmp[63:32] <= bmerge(m_cmp[63:32], APB_pdata, APB_pstb);
                    5'h10: if (APB_pstb[0]) begin
                        m_en <= APB_pdata[0];
                        m_ie <= APB_pdata[1];
                        np   = 32'd0;
                    end
                    5'h14: begin
                        m_pre <= bmerge(m_pre, APB_pdata, APB_pstb);
                        np    = 32'd0;
                    end
                    default: ;
                endcase
            end
`ifdef APB_MTIMER_HI_LATCH_EN
            if (acc && !APB_pwrite && !werr && (o == 5'h00)) m_shadow <= m_mtime[63:32];
`endif
            m_mtime <= nt;
            m_pcnt  <= np;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_irq();
        check("interrupt_vs_model", {63'd0, interrupt}, {63'd0, m_irq});
    endtask

    // Idle cycle; returns at 1 time unit after the next rising edge.
    task automatic cycle();
        @(negedge APB_PCLK);
        chk_irq();
        @(posedge APB_PCLK);
        #1;
    endtask

    // One APB transfer (setup + access); samples outputs mid access phase.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdat, output logic e,
                        output logic [31:0] mrd, output logic merr);
        APB_paddr = a; APB_pwrite = w; APB_pdata = d; APB_pstb = s;
        APB_psel = 1'b1; APB_penable = 1'b0;
        @(posedge APB_PCLK);
        #1 APB_penable = 1'b1;
        @(negedge APB_PCLK);
        rdat = APB_prdata;
        e    = APB_perr;
        mrd  = w ? 32'd0 : model_read(a);
        merr = model_err(a, w);
        check("pready_access", {63'd0, APB_pready}, 64'd1);
        chk_irq();
        @(posedge APB_PCLK);
        #1;
        APB_psel = 1'b0; APB_penable = 1'b0; APB_pwrite = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r, mr;
        logic        e, me;
        xfer(a, 1'b1, d, 4'hF, r, e, mr, me);
        check("wr_perr", {63'd0, e}, {63'd0, me});
    endtask

    task automatic rd32(input logic [31:0] a, output logic [31:0] r, output logic [31:0] mr);
        logic e, me;
        xfer(a, 1'b0, 32'd0, 4'h0, r, e, mr, me);
        check("rd_perr", {63'd0, e}, {63'd0, me});
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [3:0]  stb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] r, mr, ra;
        logic        e, me, w;
        logic [4:0]  off;
        int          rise;

        APB_PRESETn = 1'b0;
        APB_paddr = '0; APB_pdata = '0; APB_psel = 1'b0; APB_penable = 1'b0;
        APB_pwrite = 1'b0; APB_pstb = '0;
        repeat (3) @(posedge APB_PCLK);
        #1 APB_PRESETn = 1'b1;
        check("rst_interrupt", {63'd0, interrupt}, 64'd0);
        check("rst_prdata", {32'd0, APB_prdata}, 64'd0);
        check("rst_pready", {63'd0, APB_pready}, 64'd0);
        check("rst_perr", {63'd0, APB_perr}, 64'd0);

        // ---- register map / reset values / strobes / errors ----
        tbl.push_back('{32'h00, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0});
        tbl.push_back('{32'h04, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0});
        tbl.push_back('{32'h08, 1'b0, 32'h0,        4'h0, 32'hFFFFFFFF, 1'b0});
        tbl.push_back('{32'h0C, 1'b0, 32'h0,        4'h0, 32'hFFFFFFFF, 1'b0});
        tbl.push_back('{32'h10, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0});
        tbl.push_back('{32'h14, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0});
        tbl.push_back('{32'h18, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0});
        tbl.push_back('{32'h1C, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1});
        tbl.push_back('{32'h14, 1'b1, 32'hAABBCCDD, 4'h4, 32'h0,        1'b0});
        tbl.push_back('{32'h14, 1'b0, 32'h0,        4'h0, 32'h00BB0000, 1'b0});
        tbl.push_back('{32'h16, 1'b1, 32'h12345678, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{32'h1C, 1'b1, 32'h1,        4'hF, 32'h0,        1'b1});
        tbl.push_back('{32'h18, 1'b1, 32'h1,        4'hF, 32'h0,        1'b1});
        tbl.push_back('{32'h02, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1});
        tbl.push_back('{32'h14, 1'b0, 32'h0,        4'h0, 32'h00BB0000, 1'b0});
        tbl.push_back('{32'h10, 1'b1, 32'hFFFFFFFE, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{32'h10, 1'b0, 32'h0,        4'h0, 32'h2,        1'b0});
        tbl.push_back('{32'h0C, 1'b1, 32'h12345678, 4'h3, 32'h0,        1'b0});
        tbl.push_back('{32'h0C, 1'b0, 32'h0,        4'h0, 32'hFFFF5678, 1'b0});
        tbl.push_back('{32'h0C, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{32'h10, 1'b1, 32'h0,        4'hF, 32'h0,        1'b0});
        tbl.push_back('{32'h14, 1'b1, 32'h0,        4'hF, 32'h0,        1'b0});
        tbl.push_back('{32'h14, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0});
        tbl.push_back('{32'h00, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            xfer(tbl[i].addr, tbl[i].wr, tbl[i].data, tbl[i].stb, r, e, mr, me);
            check($sformatf("vec%0d_rdata", i), {32'd0, r}, {32'd0, tbl[i].exp_rd});
            check($sformatf("vec%0d_perr", i), {63'd0, e}, {63'd0, tbl[i].exp_err});
        end

        // ---- prescaler: PRESCALE=3, ~40 cycles -> about 10 ticks ----
        wr32(32'h14, 32'd3);
        wr32(32'h10, 32'd1);
        repeat (39) cycle();
        rd32(32'h00, r, mr);
        check("presc_mtime_range", {63'd0, (r >= 32'd9 && r <= 32'd11)}, 64'd1);
        check("presc_mtime_model", {32'd0, r}, {32'd0, mr});

        // ---- interrupt rise / fall latency ----
        wr32(32'h10, 32'd0);
        wr32(32'h00, 32'd0);
        wr32(32'h04, 32'd0);
        wr32(32'h0C, 32'd0);
        wr32(32'h08, 32'd5);
        wr32(32'h14, 32'd0);
        wr32(32'h10, 32'd3);
        rise = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge APB_PCLK);
            chk_irq();
            if (interrupt && rise < 0) rise = c;
            @(posedge APB_PCLK);
            #1;
        end
        check("irq_rise_cycle", 64'(rise), 64'd6);
        wr32(32'h08, 32'd1000);
        check("irq_still_high_at_commit", {63'd0, interrupt}, 64'd1);
        @(posedge APB_PCLK);
        #1;
        check("irq_fall_next_cycle", {63'd0, interrupt}, 64'd0);
        wr32(32'h10, 32'd0);

        // ---- 64-bit wrap: all-ones + 2 ticks -> 1 ----
        wr32(32'h00, 32'hFFFFFFFF);
        wr32(32'h04, 32'hFFFFFFFF);
        wr32(32'h10, 32'd1);
        wr32(32'h10, 32'd0);
        rd32(32'h00, r, mr);
        check("wrap_lo", {32'd0, r}, 64'd1);
        rd32(32'h04, r, mr);
        check("wrap_hi", {32'd0, r}, 64'd0);

        // ---- MTIME_HI read coherence across a carry ----
        wr32(32'h00, 32'hFFFFFFFF);
        wr32(32'h04, 32'h0);
        rd32(32'h00, r, mr);
        check("hilatch_lo", {32'd0, r}, 64'h0FFFFFFFF);
        wr32(32'h10, 32'd1);
        wr32(32'h10, 32'd0);
        rd32(32'h04, r, mr);
`ifdef APB_MTIMER_HI_LATCH_EN
        check("hilatch_hi_shadow", {32'd0, r}, 64'd0);
`else
        check("hilatch_hi_live", {32'd0, r}, 64'd1);
`endif
        check("hilatch_hi_model", {32'd0, r}, {32'd0, mr});

        // ---- randomized transfers against the model ----
        for (int n = 0; n < 300; n++) begin
            off = 5'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 7) == 0) off[1:0] = 2'($urandom_range(1, 3));
            ra = $urandom();
            ra[4:0] = off;
            w = 1'($urandom_range(0, 1));
            r = $urandom();
            if (off == 5'h14) r = $urandom_range(0, 3);
            xfer(ra, w, r, 4'($urandom_range(0, 15)), r, e, mr, me);
            check("rnd_rdata", {32'd0, r}, {32'd0, mr});
            check("rnd_perr", {63'd0, e}, {63'd0, me});
            repeat ($urandom_range(0, 2)) cycle();
        end

        // ---- asynchronous reset in the middle of an access phase ----
        wr32(32'h08, 32'd0);
        wr32(32'h0C, 32'd0);
        wr32(32'h10, 32'd2);
        cycle();
        check("pre_reset_irq", {63'd0, interrupt}, 64'd1);
        APB_paddr = 32'h10; APB_pwrite = 1'b0; APB_pstb = 4'h0;
        APB_psel = 1'b1; APB_penable = 1'b0;
        @(posedge APB_PCLK);
        #1 APB_penable = 1'b1;
        #1;
        check("pre_reset_prdata", {32'd0, APB_prdata}, 64'd2);
        #1 APB_PRESETn = 1'b0;
        #1;
        check("midrst_pready", {63'd0, APB_pready}, 64'd0);
        check("midrst_perr", {63'd0, APB_perr}, 64'd0);
        check("midrst_prdata", {32'd0, APB_prdata}, 64'd0);
        check("midrst_irq", {63'd0, interrupt}, 64'd0);
        APB_psel = 1'b0; APB_penable = 1'b0;
        @(posedge APB_PCLK);
        #1 APB_PRESETn = 1'b1;
        rd32(32'h10, r, mr);
        check("postrst_ctrl", {32'd0, r}, 64'd0);
        rd32(32'h08, r, mr);
        check("postrst_cmp_lo", {32'd0, r}, 64'hFFFFFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
